// File: rtl/mem_bus_controller.sv
// Sequential CPU-to-slave bus controller: registers a decoded request, strobes one slave,
// waits for its ack or a timeout, and returns a single-cycle ready/error response.
module mem_bus_controller #(
    parameter int unsigned TIMEOUT        = 16,
    parameter bit          FLASH_WRITABLE = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    be,
    input  logic          bram_select,
    input  logic          sram_select,
    input  logic          flash_select,
    input  logic          peripheral_select,
    output logic          ready,
    output logic [31:0]   rdata,
    output logic          error,
    output logic [31:0]   s_addr,
    output logic [31:0]   s_wdata,
    output logic [3:0]    s_be,
    output logic          s_we,
    output logic [3:0]    s_stb,
    input  logic [3:0]    s_ack,
    input  logic [127:0]  s_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t       state_q;
    logic [7:0]   cnt_q;
    logic         ready_q;
    logic         error_q;
    logic [31:0]  rdata_q;
    logic [3:0]   stb_q;
    logic [31:0]  addr_q;
    logic [31:0]  wdata_q;
    logic [3:0]   be_q;
    logic         we_q;

    logic [3:0]   sel_pri;
    logic         ack_hit;
    logic         illegal;
    logic [31:0]  slave_rd;

    // Lowest-numbered region wins when the decoder raises more than one select.
    always_comb begin
        sel_pri = '0;
        if (bram_select)            sel_pri = 4'b0001;
        else if (sram_select)       sel_pri = 4'b0010;
        else if (flash_select)      sel_pri = 4'b0100;
        else if (peripheral_select) sel_pri = 4'b1000;
    end

    always_comb begin
        slave_rd = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (stb_q[i]) slave_rd = s_rdata[32*i +: 32];
        end
    end

    assign ack_hit = |(s_ack & stb_q);
    assign illegal = (sel_pri == 4'b0000) || (sel_pri[2] && we && !FLASH_WRITABLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
            stb_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        be_q    <= be;
                        we_q    <= we;
                        if (illegal) begin
                            ready_q <= 1'b1;
                            error_q <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            stb_q   <= sel_pri;
                            cnt_q   <= '0;
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Ack is tested first so it beats a timeout firing in the same cycle.
                    if (ack_hit) begin
                        stb_q   <= '0;
                        ready_q <= 1'b1;
                        rdata_q <= we_q ? 32'h0 : slave_rd;
                        state_q <= RESP;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        stb_q   <= '0;
                        ready_q <= 1'b1;
                        error_q <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready   = ready_q;
    assign error   = error_q;
    assign rdata   = rdata_q;
    assign s_stb   = stb_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign s_be    = be_q;
    assign s_we    = we_q;

endmodule

// File: tb/tb_mem_bus_controller.sv
// Randomized self-checking bench for mem_bus_controller; a transaction-level model predicts
// response latency, strobe window, error and read data from the region and slave ack delay.
module tb_mem_bus_controller;

    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req, we;
    logic [31:0]   addr, wdata;
    logic [3:0]    be;
    logic          bram_select, sram_select, flash_select, peripheral_select;
    logic          ready, error, s_we;
    logic [31:0]   rdata, s_addr, s_wdata;
    logic [3:0]    s_be, s_stb, s_ack;
    logic [127:0]  s_rdata;

    int checks   = 0;
    int failures = 0;

    mem_bus_controller #(.TIMEOUT(TO), .FLASH_WRITABLE(1'b0)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .bram_select(bram_select), .sram_select(sram_select),
        .flash_select(flash_select), .peripheral_select(peripheral_select),
        .ready(ready), .rdata(rdata), .error(error),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be), .s_we(s_we),
        .s_stb(s_stb), .s_ack(s_ack), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, {31'b0, ready}, 32'd0);
        chk({tag, "_error"}, {31'b0, error}, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_stb"},   {28'b0, s_stb}, 32'd0);
    endtask

    // d = strobe cycle in which the slave acks (0 = never); spur = random acks from other slaves.
    task automatic run_txn(input logic [3:0] sel, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] b, input int d,
                           input bit spur, input logic [31:0] sd);
        int tgt, lat, cnt;
        logic [3:0] tgt_vec, stb_exp;
        logic err_exp;
        logic [31:0] rd_exp;
        tgt = -1;
        for (int i = 3; i >= 0; i--) if (sel[i]) tgt = i;
        tgt_vec = (tgt >= 0) ? (4'b0001 << tgt) : 4'b0000;
        if (tgt < 0 || (tgt == 2 && w)) begin
            lat = 0; err_exp = 1'b1;
        end else if (d >= 1 && d <= TO) begin
            lat = d; err_exp = 1'b0;
        end else begin
            lat = TO; err_exp = 1'b1;
        end
        rd_exp = 32'h0;
        cnt = 0;
        req = 1'b1; we = w; addr = a; wdata = wd; be = b;
        {peripheral_select, flash_select, sram_select, bram_select} = sel;
        for (int n = 0; n <= lat; n++) begin
            @(posedge clk); #1;
            stb_exp = (n < lat) ? tgt_vec : 4'b0000;
            chk("stb", {28'b0, s_stb}, {28'b0, stb_exp});
            chk("ready", {31'b0, ready}, {31'b0, (n == lat)});
            if (n == lat) begin
                req = 1'b0;
                chk("error", {31'b0, error}, {31'b0, err_exp});
                chk("rdata", rdata, rd_exp);
                chk("s_addr", s_addr, a);
                chk("s_wdata", s_wdata, wd);
                chk("s_be", {28'b0, s_be}, {28'b0, b});
                chk("s_we", {31'b0, s_we}, {31'b0, w});
            end
            s_rdata = {$urandom, $urandom, $urandom, $urandom};
            s_ack = spur ? (4'($urandom) & ~tgt_vec) : 4'b0000;
            if (tgt >= 0 && s_stb[tgt]) begin
                s_rdata[32*tgt +: 32] = sd;
                cnt++;
                if (cnt == d) begin
                    s_ack[tgt] = 1'b1;
                    if (!w) rd_exp = sd;
                end
            end
        end
        s_ack = 4'b0000;
        @(posedge clk); #1;
        check_idle_outputs("post");
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        {peripheral_select, flash_select, sram_select, bram_select} = 4'b0000;
        s_ack = '0; s_rdata = '0;
        #1;
        check_idle_outputs("rst");
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_s_we", {31'b0, s_we}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("after_rst");

        run_txn(4'b0001, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1, 1'b0, 32'hDEAD_BEEF);
        run_txn(4'b0010, 1'b1, 32'h0001_0004, 32'h1234_5678, 4'b0011, 5, 1'b0, 32'hCAFE_F00D);
        run_txn(4'b0000, 1'b0, 32'h0005_0000, 32'h0, 4'hF, 1, 1'b0, 32'h1111_1111);
        run_txn(4'b0100, 1'b1, 32'h0002_0000, 32'hA5A5_A5A5, 4'hF, 1, 1'b0, 32'h2222_2222);
        run_txn(4'b0100, 1'b0, 32'h0002_0000, 32'h0, 4'hF, 3, 1'b0, 32'h3333_3333);
        run_txn(4'b1000, 1'b0, 32'h0003_0000, 32'h0, 4'hF, 0, 1'b1, 32'h4444_4444);
        run_txn(4'b1000, 1'b0, 32'h0003_0008, 32'h0, 4'hF, TO, 1'b1, 32'h5555_5555);
        run_txn(4'b1000, 1'b0, 32'h0003_000C, 32'h0, 4'hF, TO + 1, 1'b0, 32'h6666_6666);
        run_txn(4'b0110, 1'b1, 32'h0001_0020, 32'h7777_7777, 4'b1100, 2, 1'b1, 32'h8888_8888);

        // Reset in the third strobe cycle of a BRAM read.
        req = 1'b1; we = 1'b0; addr = 32'h0000_0040; wdata = '0; be = 4'hF;
        {peripheral_select, flash_select, sram_select, bram_select} = 4'b0001;
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_abort_stb", {28'b0, s_stb}, 32'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        chk("abort_s_addr", s_addr, 32'd0);
        chk("abort_s_be", {28'b0, s_be}, 32'd0);
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; check_idle_outputs("abort_quiet"); end
        run_txn(4'b0001, 1'b0, 32'h0000_0044, 32'h0, 4'hF, 1, 1'b0, 32'h0BAD_F00D);

        for (int t = 0; t < 40; t++) begin
            logic [3:0] rs;
            rs = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            run_txn(rs, 1'($urandom), $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, TO + 3), 1'($urandom), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
